// File: rtl/sfq_mon_pkg.sv
// Shared types and defaults for the SFQ DFF pulse monitor.
// Optional feature macro used by the top level: SFQ_MON_STICKY_ERR_EN.
package sfq_mon_pkg;

  // Expected DFF storage state as seen by the monitor.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    READ  = 2'd2
  } mon_state_t;

  // Bit positions of the error flags inside the internal error vector.
  typedef enum int unsigned {
    ERR_UNEXP = 0,
    ERR_MISS  = 1,
    ERR_RACE  = 2
  } err_t;

  localparam int NUM_ERR         = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 16;
  localparam int DEF_TMR_W       = 8;
  localparam int DEF_CNT_W       = 16;

endpackage : sfq_mon_pkg

// File: rtl/sfq_dff_pulse_monitor_if.sv
// Signal bundle between a toggle-encoded RSFQ DFF model and its pulse monitor.
// master: side that drives the toggle lines and observes the results.
// slave : the monitor itself.
interface sfq_dff_pulse_monitor_if #(
  parameter int CNT_W = 16
);

  logic             set_tgl;
  logic             reset_tgl;
  logic             out_tgl;
  logic             set_pls;
  logic             reset_pls;
  logic             out_pls;
  logic             dff_state;
  logic             err_unexp;
  logic             err_miss;
  logic             err_race;
  logic [CNT_W-1:0] read_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output set_tgl, reset_tgl, out_tgl,
    input  set_pls, reset_pls, out_pls, dff_state,
    input  err_unexp, err_miss, err_race, read_cnt, err_cnt
  );

  modport slave (
    input  set_tgl, reset_tgl, out_tgl,
    output set_pls, reset_pls, out_pls, dff_state,
    output err_unexp, err_miss, err_race, read_cnt, err_cnt
  );

endinterface : sfq_dff_pulse_monitor_if

// File: rtl/sfq_toggle_sync.sv
// Brings one asynchronous toggle-encoded line into the clk domain and turns
// each toggle into a registered one-cycle strobe. Toggle-to-strobe latency is
// SYNC_STAGES+1 cycles; toggles closer than two cycles may merge.
module sfq_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pls
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain, edge-detect history and registered strobe.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: the synchronizer and history are reset to 0 on purpose, so the first
  // post-reset sample that differs from 0 is treated as a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pls    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      hist_q <= sync_q[SYNC_STAGES-1];
      pls    <= sync_q[SYNC_STAGES-1] ^ hist_q;
    end
  end

endmodule : sfq_toggle_sync

// File: rtl/sfq_dff_pulse_monitor.sv
// Receive-side checker for a toggle-encoded RSFQ DFF model.
// Converts set/reset/out toggles into strobes, tracks the expected stored bit,
// checks that a readout pulse follows each clocked-out 1 within TIMEOUT cycles,
// and counts readouts and errors (saturating).
// Build option: define SFQ_MON_STICKY_ERR_EN to make err_* flags hold until rst;
// otherwise each err_* is a one-cycle strobe in the detection cycle.
module sfq_dff_pulse_monitor
  import sfq_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TMR_W       = DEF_TMR_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  sfq_dff_pulse_monitor_if.slave mon
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT >= (2 ** TMR_W)) begin : g_bad_tmr
    $error("TIMEOUT must fit in TMR_W bits");
  end

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic set_pls;
  logic reset_pls;
  logic out_pls;

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set (
    .clk (clk),
    .rst (rst),
    .tgl (mon.set_tgl),
    .pls (set_pls)
  );

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_reset (
    .clk (clk),
    .rst (rst),
    .tgl (mon.reset_tgl),
    .pls (reset_pls)
  );

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_out (
    .clk (clk),
    .rst (rst),
    .tgl (mon.out_tgl),
    .pls (out_pls)
  );

  mon_state_t         state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pend_q, pend_d;
  logic [NUM_ERR-1:0] err_det;
  logic               read_inc;
  logic [CNT_W-1:0]   read_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [NUM_ERR-1:0] err_flags;

  // Next-state, timer and error detection for the expected DFF contents.
  // The timer holds the cycles left in the readout window including the
  // current one, so an out strobe up to TIMEOUT cycles after the reset strobe
  // is accepted and err_miss fires in the last cycle of the window.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    err_det  = '0;
    read_inc = 1'b0;

    if (set_pls && reset_pls) err_det[ERR_RACE] = 1'b1;
    if (out_pls && (state_q != READ)) err_det[ERR_UNEXP] = 1'b1;

    unique case (state_q)
      EMPTY: begin
        if (set_pls && !reset_pls) state_d = FULL;
      end
      FULL: begin
        if (set_pls && reset_pls) begin
          state_d = EMPTY;
        end else if (reset_pls) begin
          state_d = READ;
          timer_d = TMR_LOAD;
          pend_d  = 1'b0;
        end
      end
      READ: begin
        if (out_pls) begin
          read_inc = 1'b1;
          state_d  = (set_pls || pend_q) ? FULL : EMPTY;
          pend_d   = 1'b0;
          timer_d  = '0;
        end else if (timer_q <= TMR_ONE) begin
          err_det[ERR_MISS] = 1'b1;
          state_d = (set_pls || pend_q) ? FULL : EMPTY;
          pend_d  = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_ONE;
          if (set_pls) pend_d = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        timer_d = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State register, readout timer, pending-set latch and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      read_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      if (read_inc && (read_cnt_q != CNT_MAX)) read_cnt_q <= read_cnt_q + 1'b1;
      if ((|err_det) && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

`ifdef SFQ_MON_STICKY_ERR_EN
  logic [NUM_ERR-1:0] err_sticky_q;

  // Error flags hold from their first occurrence until rst.
  always_ff @(posedge clk) begin
    if (rst) err_sticky_q <= '0;
    else     err_sticky_q <= err_sticky_q | err_det;
  end

  assign err_flags = rst ? '0 : (err_sticky_q | err_det);
`else
  assign err_flags = rst ? '0 : err_det;
`endif

  assign mon.set_pls   = set_pls;
  assign mon.reset_pls = reset_pls;
  assign mon.out_pls   = out_pls;
  assign mon.dff_state = (state_q == FULL) || ((state_q == READ) && pend_q);
  assign mon.err_unexp = err_flags[ERR_UNEXP];
  assign mon.err_miss  = err_flags[ERR_MISS];
  assign mon.err_race  = err_flags[ERR_RACE];
  assign mon.read_cnt  = read_cnt_q;
  assign mon.err_cnt   = err_cnt_q;

endmodule : sfq_dff_pulse_monitor
